photon_deadlock_reporter: RTL and testbench

- Receives the per-instance `block` flags produced by the HLS deadlock monitors in the photon pipeline.
- Confirms a deadlock only when a flag persists for a programmable number of cycles.
- On confirmation, transmits a single-beat diagnostic record on an AXI4-Stream master, then holds a sticky status until software clears it.
- It is the reporting end of the monitor chain: the monitors detect, this block qualifies and transmits.

---
 rtl/photon_diag_pkg.sv | 35 +++
 rtl/photon_persist_counter.sv | 41 ++++
 rtl/photon_deadlock_reporter.sv | 119 +++++++++++
 tb/tb_photon_deadlock_reporter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/photon_diag_pkg.sv
// Shared definitions for the photon deadlock diagnostic path: record tag,
// record field offsets, reporter FSM states and the record packing helper.
package photon_diag_pkg;

  localparam logic [7:0] DIAG_TAG_DEADLOCK = 8'hD1;

  localparam int REC_W        = 64;
  localparam int REC_TAG_LSB  = 56;
  localparam int REC_RSVD_LSB = 52;
  localparam int REC_IDX_LSB  = 48;
  localparam int REC_MASK_LSB = 32;
  localparam int REC_TS_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    REPORT  = 2'd2,
    LATCHED = 2'd3
  } state_t;

  // Packs a deadlock record: tag, reserved nibble, winner index, block mask, timestamp.
  function automatic logic [REC_W-1:0] build_record(input logic [3:0]  idx,
                                                    input logic [15:0] mask,
                                                    input logic [31:0] ts);
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[REC_TAG_LSB  +: 8]  = DIAG_TAG_DEADLOCK;
    rec[REC_RSVD_LSB +: 4]  = 4'h0;
    rec[REC_IDX_LSB  +: 4]  = idx;
    rec[REC_MASK_LSB +: 16] = mask;
    rec[REC_TS_LSB   +: 32] = ts;
    return rec;
  endfunction

endpackage

// File: rtl/photon_persist_counter.sv
// Per-monitor persistence counter: counts consecutive high samples of one
// block flag while the reporter is watching, and flags the sample that makes
// the run reach PERSIST_CYCLES.
module photon_persist_counter #(
  parameter int PERSIST_CYCLES = 1024,
  parameter int CNT_W          = $clog2(PERSIST_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic block_i,
  output logic confirm_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERSIST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: any low sample or inactivity restarts the run; saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || !block_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign confirm_o = active_i && block_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/photon_deadlock_reporter.sv
// Deadlock reporter: qualifies monitor block flags by persistence, sends one
// single-beat AXI4-Stream diagnostic record per episode, and keeps a sticky
// deadlock flag until software clears it.
module photon_deadlock_reporter
  import photon_diag_pkg::*;
#(
  parameter int N_MON          = 4,
  parameter int PERSIST_CYCLES = 1024,
  parameter int TS_W           = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [N_MON-1:0] block_in,
  input  logic             enable,
  input  logic             clear,
  output logic [63:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             deadlock,
  output logic [3:0]       first_idx
);

  localparam int CNT_W = $clog2(PERSIST_CYCLES + 1);

  state_t           state_q, state_d;
  logic [TS_W-1:0]  ts_q;
  logic [63:0]      tdata_q, tdata_d;
  logic [3:0]       first_idx_q, first_idx_d;
  logic             deadlock_q, deadlock_d;
  logic [N_MON-1:0] confirm;
  logic             any_confirm;
  logic [3:0]       win_idx;
  logic             cnt_active;

  // Counters only run in WATCH with enable still high; dropping enable zeroes them.
  assign cnt_active = (state_q == WATCH) && enable;

  for (genvar i = 0; i < N_MON; i++) begin : g_cnt
    photon_persist_counter #(
      .PERSIST_CYCLES (PERSIST_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cnt (
      .clk_i     (ap_clk),
      .rst_ni    (ap_rst_n),
      .active_i  (cnt_active),
      .block_i   (block_in[i]),
      .confirm_o (confirm[i])
    );
  end

  // Priority encoder: scanning downward lets the lowest confirming index win.
  always_comb begin
    win_idx     = '0;
    any_confirm = |confirm;
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (confirm[i]) begin
        win_idx = 4'(i);
      end
    end
  end

  // Next-state and record capture; REPORT ignores enable/clear until the handshake.
  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    first_idx_d = first_idx_q;
    deadlock_d  = deadlock_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WATCH;
      end
      WATCH: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (any_confirm) begin
          state_d     = REPORT;
          first_idx_d = win_idx;
          deadlock_d  = 1'b1;
          tdata_d     = build_record(win_idx, 16'(block_in), 32'(ts_q));
        end
      end
      REPORT: begin
        if (m_axis_tready) state_d = LATCHED;
      end
      LATCHED: begin
        if (clear) begin
          deadlock_d = 1'b0;
          state_d    = enable ? WATCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, record and free-running timestamp registers.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      ts_q        <= '0;
      tdata_q     <= '0;
      first_idx_q <= '0;
      deadlock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_q + TS_W'(1);
      tdata_q     <= tdata_d;
      first_idx_q <= first_idx_d;
      deadlock_q  <= deadlock_d;
    end
  end

  assign m_axis_tvalid = (state_q == REPORT);
  assign m_axis_tlast  = (state_q == REPORT);
  assign m_axis_tdata  = tdata_q;
  assign deadlock      = deadlock_q;
  assign first_idx     = first_idx_q;

endmodule

// File: tb/tb_photon_deadlock_reporter.sv
// Self-checking bench for photon_deadlock_reporter with PERSIST_CYCLES=16:
// a table of single-episode vectors plus hand-written multi-cycle sequences.
module tb_photon_deadlock_reporter;

  localparam int P = 16;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [3:0]  block_in;
  logic        enable;
  logic        clear;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        deadlock;
  logic [3:0]  first_idx;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] tsModel;

  typedef struct {
    logic [3:0] blockPat;
    int         startTs;
    int         holdCycles;
    logic       expValid;
    logic [3:0] expIdx;
  } vec_t;

  vec_t vecs[6];

  photon_deadlock_reporter #(
    .N_MON          (4),
    .PERSIST_CYCLES (P),
    .TS_W           (32)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .block_in      (block_in),
    .enable        (enable),
    .clear         (clear),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .deadlock      (deadlock),
    .first_idx     (first_idx)
  );

  // 10 ns clock.
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Reference timestamp: counts edges since the last reset edge.
  always @(posedge ap_clk) begin
    if (!ap_rst_n) tsModel <= 32'd0;
    else           tsModel <= tsModel + 32'd1;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] expRecord(input logic [3:0] idx, input logic [3:0] mask,
                                            input logic [31:0] ts);
    return {8'hD1, 4'h0, idx, 12'h000, mask, ts};
  endfunction

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] blk, input logic en, input logic clr,
                               input logic rdy);
    block_in      = blk;
    enable        = en;
    clear         = clr;
    m_axis_tready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] expTs;
    logic [63:0] expData;
    int          w;

    vecs[0] = '{blockPat: 4'b0100, startTs: 100, holdCycles: P,      expValid: 1'b1, expIdx: 4'd2};
    vecs[1] = '{blockPat: 4'b1010, startTs: 5,   holdCycles: P,      expValid: 1'b1, expIdx: 4'd1};
    vecs[2] = '{blockPat: 4'b0001, startTs: 7,   holdCycles: P - 1,  expValid: 1'b0, expIdx: 4'd0};
    vecs[3] = '{blockPat: 4'b1000, startTs: 3,   holdCycles: P,      expValid: 1'b1, expIdx: 4'd3};
    vecs[4] = '{blockPat: 4'b1111, startTs: 9,   holdCycles: P,      expValid: 1'b1, expIdx: 4'd0};
    vecs[5] = '{blockPat: 4'b0000, startTs: 4,   holdCycles: 3 * P,  expValid: 1'b0, expIdx: 4'd0};

    ap_rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    doReset();
    checkOutput("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("reset_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("reset_tdata", m_axis_tdata, 64'd0);
    checkOutput("reset_deadlock", 64'(deadlock), 64'd0);
    checkOutput("reset_first_idx", 64'(first_idx), 64'd0);

    // Table-driven single episodes.
    for (int v = 0; v < 6; v++) begin
      doReset();
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
      w = 0;
      while (tsModel != 32'(vecs[v].startTs) && w < 1000) begin
        tick();
        w++;
      end
      if (w >= 1000) begin
        checks++;
        errors++;
        $display("[TB] FAIL vec%0d_start_wait: got ts 0x%0h required 0x%0h", v, tsModel,
                 vecs[v].startTs);
      end
      expTs = tsModel + 32'(vecs[v].holdCycles) - 32'd1;
      applyStimulus(vecs[v].blockPat, 1'b1, 1'b0, 1'b0);
      repeat (vecs[v].holdCycles) tick();
      checkOutput($sformatf("vec%0d_tvalid", v), 64'(m_axis_tvalid), 64'(vecs[v].expValid));
      checkOutput($sformatf("vec%0d_deadlock", v), 64'(deadlock), 64'(vecs[v].expValid));
      if (vecs[v].expValid) begin
        checkOutput($sformatf("vec%0d_tlast", v), 64'(m_axis_tlast), 64'd1);
        checkOutput($sformatf("vec%0d_first_idx", v), 64'(first_idx), 64'(vecs[v].expIdx));
        checkOutput($sformatf("vec%0d_tdata", v), m_axis_tdata,
                    expRecord(vecs[v].expIdx, vecs[v].blockPat, expTs));
      end
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("vec%0d_post_tvalid", v), 64'(m_axis_tvalid), 64'd0);
      checkOutput($sformatf("vec%0d_post_deadlock", v), 64'(deadlock), 64'(vecs[v].expValid));
    end

    // The first vector must match the hand-computed record exactly (ts 100 + 15).
    doReset();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (100) tick();
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
    repeat (P) tick();
    checkOutput("sustained_tdata", m_axis_tdata, 64'hD102_0004_0000_0073);
    checkOutput("sustained_tvalid", 64'(m_axis_tvalid), 64'd1);
    tick();
    checkOutput("sustained_single_beat", 64'(m_axis_tvalid), 64'd0);

    // Glitch rejection: 15 high, 1 low, 15 high.
    doReset();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
    repeat (P - 1) tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
    repeat (P - 1) tick();
    checkOutput("glitch_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("glitch_deadlock", 64'(deadlock), 64'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();

    // Backpressure with clear/enable toggling, then sticky LATCHED and re-arm.
    doReset();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    expTs = tsModel + 32'(P) - 32'd1;
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    repeat (P) tick();
    expData = expRecord(4'd2, 4'b0100, expTs);
    checkOutput("bp_rise_tvalid", 64'(m_axis_tvalid), 64'd1);
    for (int k = 0; k < 50; k++) begin
      applyStimulus(4'b0000, 1'(k % 2), 1'((k % 7) == 0), 1'b0);
      tick();
      checkOutput($sformatf("bp_hold_tvalid_%0d", k), 64'(m_axis_tvalid), 64'd1);
      checkOutput($sformatf("bp_hold_tdata_%0d", k), m_axis_tdata, expData);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("bp_xfer_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("bp_xfer_deadlock", 64'(deadlock), 64'd1);

    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3 * P; k++) begin
      tick();
      checkOutput($sformatf("sticky_no_record_%0d", k), 64'(m_axis_tvalid), 64'd0);
    end
    checkOutput("sticky_deadlock", 64'(deadlock), 64'd1);

    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_deadlock", 64'(deadlock), 64'd0);
    expTs = tsModel + 32'(P) - 32'd1;
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    repeat (P) tick();
    checkOutput("rearm_tvalid", 64'(m_axis_tvalid), 64'd1);
    checkOutput("rearm_tdata", m_axis_tdata, expRecord(4'd3, 4'b1000, expTs));
    checkOutput("rearm_deadlock", 64'(deadlock), 64'd1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("rearm_xfer_tvalid", 64'(m_axis_tvalid), 64'd0);

    // Reset while a record is stalled.
    doReset();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    repeat (P) tick();
    checkOutput("midrst_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("midrst_deadlock", 64'(deadlock), 64'd0);
    checkOutput("midrst_tdata", m_axis_tdata, 64'd0);
    checkOutput("midrst_first_idx", 64'(first_idx), 64'd0);
    repeat (20) tick();
    checkOutput("midrst_idle_no_record", 64'(m_axis_tvalid), 64'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    repeat (P) tick();
    checkOutput("midrst_ts_restart_tvalid", 64'(m_axis_tvalid), 64'd1);
    checkOutput("midrst_ts_restart_tdata", m_axis_tdata, 64'hD100_0001_0000_0024);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
